// File: rtl/display_controller.sv
// rtl/display_controller.sv - guess entry, history browsing and cursor blink timing
// for a four-LED colour guessing display.
module display_controller #(
    parameter int BLINK_DIV  = 25000000,
    parameter int HIST_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_color,
    input  logic        btn_submit,
    input  logic        btn_mode,
    output logic        blink_enable,
    output logic [1:0]  blink_led,
    output logic        blink_tick,
    output logic [2:0]  guess_rgb0,
    output logic [2:0]  guess_rgb1,
    output logic [2:0]  guess_rgb2,
    output logic [2:0]  guess_rgb3,
    output logic [2:0]  history_rgb0,
    output logic [2:0]  history_rgb1,
    output logic [2:0]  history_rgb2,
    output logic [2:0]  history_rgb3,
    output logic [4:0]  hist_count,
    output logic [3:0]  hist_index,
    output logic        guess_valid,
    output logic [11:0] guess_word
);

    localparam int          IW       = $clog2(HIST_DEPTH);
    localparam logic [4:0]  DEPTH    = 5'(HIST_DEPTH);
    localparam logic [25:0] DIV_LAST = 26'(BLINK_DIV - 1);

    typedef enum logic [1:0] {S_GUESS, S_COMMIT, S_HISTORY} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_blink_en;
    logic [1:0]  r_led;
    logic [25:0] r_cnt;
    logic        r_tick;
    logic [2:0]  r_guess [0:3];
    logic [4:0]  r_hist_count;
    logic [3:0]  r_hist_index;
    logic [11:0] r_mem [0:HIST_DEPTH-1];

    logic        w_commit;
    logic        w_led_inc;
    logic        w_led_dec;
    logic        w_color;
    logic        w_idx_inc;
    logic        w_idx_dec;
    logic        w_enter_hist;
    logic [4:0]  w_cnt_m1;
    logic [11:0] w_hist_entry;

    assign w_cnt_m1 = r_hist_count - 5'd1;

    // Only the highest-priority asserted button is decoded into an action.
    always_comb begin
        w_next       = r_state;
        w_commit     = 1'b0;
        w_led_inc    = 1'b0;
        w_led_dec    = 1'b0;
        w_color      = 1'b0;
        w_idx_inc    = 1'b0;
        w_idx_dec    = 1'b0;
        w_enter_hist = 1'b0;
        case (r_state)
            S_GUESS: begin
                if (btn_mode) begin
                    w_next       = S_HISTORY;
                    w_enter_hist = 1'b1;
                end else if (btn_submit) begin
                    if (r_hist_count < DEPTH) begin
                        w_next   = S_COMMIT;
                        w_commit = 1'b1;
                    end
                end else if (btn_color) begin
                    w_color = 1'b1;
                end else if (btn_right) begin
                    w_led_inc = 1'b1;
                end else if (btn_left) begin
                    w_led_dec = 1'b1;
                end
            end
            S_COMMIT: w_next = S_GUESS;
            S_HISTORY: begin
                if (btn_mode) begin
                    w_next = S_GUESS;
                end else if (btn_submit || btn_color) begin
                    w_next = S_HISTORY;
                end else if (btn_right) begin
                    w_idx_inc = (r_hist_count != 5'd0);
                end else if (btn_left) begin
                    w_idx_dec = (r_hist_count != 5'd0);
                end
            end
            default: w_next = S_GUESS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_GUESS;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_en   <= 1'b1;
            r_led        <= 2'd0;
            r_cnt        <= 26'd0;
            r_tick       <= 1'b0;
            r_hist_count <= 5'd0;
            r_hist_index <= 4'd0;
            for (int i = 0; i < 4; i++) r_guess[i] <= 3'b001;
        end else begin
            r_blink_en <= (w_next != S_HISTORY);
            // User activity restarts the blink phase so the cursor is visible at once.
            if (w_led_inc || w_led_dec || w_color) begin
                r_cnt  <= 26'd0;
                r_tick <= 1'b0;
            end else if (r_cnt == DIV_LAST) begin
                r_cnt  <= 26'd0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + 26'd1;
                r_tick <= 1'b0;
            end
            if (w_led_inc) r_led <= r_led + 2'd1;
            if (w_led_dec) r_led <= r_led - 2'd1;
            if (w_color)
                r_guess[r_led] <= (r_guess[r_led] == 3'd7) ? 3'd1 : r_guess[r_led] + 3'd1;
            if (w_commit) r_hist_count <= r_hist_count + 5'd1;
            if (w_enter_hist)
                r_hist_index <= (r_hist_count == 5'd0) ? 4'd0 : w_cnt_m1[3:0];
            else if (w_idx_inc)
                r_hist_index <= (r_hist_index == w_cnt_m1[3:0]) ? 4'd0 : r_hist_index + 4'd1;
            else if (w_idx_dec)
                r_hist_index <= (r_hist_index == 4'd0) ? w_cnt_m1[3:0] : r_hist_index - 4'd1;
        end
    end

    // History storage carries no reset; hist_count alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (w_commit && !rst) r_mem[r_hist_count[IW-1:0]] <= guess_word;
    end

    assign w_hist_entry = (r_hist_count != 5'd0) ? r_mem[r_hist_index[IW-1:0]] : 12'd0;

    assign blink_enable = r_blink_en;
    assign blink_led    = r_led;
    assign blink_tick   = r_tick;
    assign guess_rgb0   = r_guess[0];
    assign guess_rgb1   = r_guess[1];
    assign guess_rgb2   = r_guess[2];
    assign guess_rgb3   = r_guess[3];
    assign guess_word   = {r_guess[3], r_guess[2], r_guess[1], r_guess[0]};
    assign history_rgb0 = w_hist_entry[2:0];
    assign history_rgb1 = w_hist_entry[5:3];
    assign history_rgb2 = w_hist_entry[8:6];
    assign history_rgb3 = w_hist_entry[11:9];
    assign hist_count   = r_hist_count;
    assign hist_index   = r_hist_index;
    assign guess_valid  = (r_state == S_COMMIT) && !rst;

endmodule

// File: tb/tb_display_controller.sv
// tb/tb_display_controller.sv - directed bench with a guess_word scoreboard
module tb_display_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0;
    logic        btn_submit = 1'b0, btn_mode = 1'b0;
    logic        blink_enable, blink_tick, guess_valid;
    logic [1:0]  blink_led;
    logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
    logic [2:0]  history_rgb0, history_rgb1, history_rgb2, history_rgb3;
    logic [4:0]  hist_count;
    logic [3:0]  hist_index;
    logic [11:0] guess_word;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_L    = 5'b00001;
    localparam logic [4:0] B_R    = 5'b00010;
    localparam logic [4:0] B_C    = 5'b00100;
    localparam logic [4:0] B_S    = 5'b01000;
    localparam logic [4:0] B_M    = 5'b10000;

    int          tests = 0;
    int          fails = 0;
    int          pulses = 0;
    logic [11:0] sb [$];
    logic [11:0] words [0:7];
    logic [11:0] w_exp;
    logic [2:0]  c2;

    always #5 clk = ~clk;

    display_controller #(.BLINK_DIV(4), .HIST_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .btn_left(btn_left), .btn_right(btn_right), .btn_color(btn_color),
        .btn_submit(btn_submit), .btn_mode(btn_mode),
        .blink_enable(blink_enable), .blink_led(blink_led), .blink_tick(blink_tick),
        .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1),
        .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
        .history_rgb0(history_rgb0), .history_rgb1(history_rgb1),
        .history_rgb2(history_rgb2), .history_rgb3(history_rgb3),
        .hist_count(hist_count), .hist_index(hist_index),
        .guess_valid(guess_valid), .guess_word(guess_word)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one button pattern across exactly one rising edge; return just after the next negedge.
    task automatic step(input logic [4:0] b);
        {btn_mode, btn_submit, btn_color, btn_right, btn_left} = b;
        @(negedge clk);
        {btn_mode, btn_submit, btn_color, btn_right, btn_left} = B_NONE;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(B_NONE);
        step(B_NONE);
        rst = 1'b0;
    endtask

    function automatic logic [11:0] hist_word();
        return {history_rgb3, history_rgb2, history_rgb1, history_rgb0};
    endfunction

    // Every guess_valid cycle must match the oldest expected commit.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (guess_valid === 1'b1) begin
                pulses++;
                tests++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_guess_valid: observed pulse word %0h expected no pulse", guess_word);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_guess_word", guess_word, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(B_NONE);
        step(B_NONE);
        rst = 1'b0;
        chk("rst_blink_enable", blink_enable, 1);
        chk("rst_blink_led", blink_led, 0);
        chk("rst_blink_tick", blink_tick, 0);
        chk("rst_guess_word", guess_word, 12'b001_001_001_001);
        chk("rst_hist_count", hist_count, 0);
        chk("rst_hist_index", hist_index, 0);
        chk("rst_guess_valid", guess_valid, 0);
        chk("rst_history_rgb", hist_word(), 0);

        for (int k = 1; k <= 8; k++) begin
            step(B_NONE);
            chk($sformatf("tick_free_%0d", k), blink_tick, (k % 4 == 0));
        end
        step(B_NONE);
        chk("tick_k9", blink_tick, 0);
        step(B_L);
        chk("left_wrap_led", blink_led, 3);
        chk("tick_after_move", blink_tick, 0);
        for (int j = 1; j <= 4; j++) begin
            step(B_NONE);
            chk($sformatf("tick_restart_%0d", j), blink_tick, (j == 4));
        end
        step(B_NONE);
        step(B_NONE);
        step(B_NONE);
        step(B_R);
        chk("tick_suppressed", blink_tick, 0);
        chk("right_wrap_led", blink_led, 0);

        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step(B_R);
            chk($sformatf("right_led_%0d", i), blink_led, i % 4);
        end
        chk("guess_after_moves", guess_word, 12'b001_001_001_001);

        step(B_R);
        step(B_R);
        for (int i = 0; i < 7; i++) begin
            step(B_C);
            chk($sformatf("color_step_%0d", i), guess_rgb2, (i == 6) ? 1 : i + 2);
        end
        chk("color_rgb0", guess_rgb0, 1);
        chk("color_rgb1", guess_rgb1, 1);
        chk("color_rgb3", guess_rgb3, 1);

        step(B_L);
        step(B_L);
        repeat (6) step(B_C);
        step(B_R);
        repeat (2) step(B_C);
        step(B_R);
        repeat (4) step(B_C);
        chk("guess_7351", guess_word, 12'b001_101_011_111);
        words[0] = 12'b001_101_011_111;
        sb.push_back(12'b001_101_011_111);
        step(B_S);
        chk("commit_valid", guess_valid, 1);
        chk("commit_word", guess_word, 12'b001_101_011_111);
        chk("commit_count", hist_count, 1);
        step(B_C);
        chk("commit_ignores_color", guess_rgb2, 5);
        chk("commit_one_cycle", guess_valid, 0);

        c2 = 3'd5;
        for (int n = 1; n <= 7; n++) begin
            step(B_C);
            c2 = (c2 == 3'd7) ? 3'd1 : c2 + 3'd1;
            w_exp = {3'd1, c2, 3'd3, 3'd7};
            words[n] = w_exp;
            sb.push_back(w_exp);
            step(B_S);
            chk($sformatf("fill_count_%0d", n), hist_count, n + 1);
            step(B_NONE);
        end
        step(B_S);
        chk("full_no_valid", guess_valid, 0);
        chk("full_count", hist_count, 8);
        chk("full_stays_guess", blink_enable, 1);
        step(B_S | B_C);
        chk("full_submit_blocks_color", guess_rgb2, c2);
        chk("pulse_count_8", pulses, 8);
        chk("sb_drained_8", sb.size(), 0);

        step(B_M);
        chk("hist8_enable", blink_enable, 0);
        chk("hist8_index", hist_index, 7);
        chk("hist8_word7", hist_word(), words[7]);
        step(B_R);
        chk("hist8_wrap_up", hist_index, 0);
        chk("hist8_word0", hist_word(), words[0]);
        step(B_L);
        chk("hist8_wrap_down", hist_index, 7);
        step(B_M);
        chk("hist8_exit", blink_enable, 1);
        chk("mode_keeps_guess", guess_rgb2, c2);

        do_reset();
        sb.push_back(12'h249);
        step(B_S);
        step(B_NONE);
        step(B_C);
        sb.push_back(12'h24A);
        step(B_S);
        step(B_NONE);
        step(B_R);
        step(B_C);
        sb.push_back(12'h252);
        step(B_S);
        step(B_NONE);
        chk("h3_count", hist_count, 3);
        step(B_M);
        chk("h3_enable", blink_enable, 0);
        chk("h3_index_newest", hist_index, 2);
        chk("h3_word2", hist_word(), 12'h252);
        step(B_R);
        chk("h3_right_wrap", hist_index, 0);
        chk("h3_word0", hist_word(), 12'h249);
        step(B_L);
        chk("h3_left_wrap", hist_index, 2);
        step(B_L);
        chk("h3_left", hist_index, 1);
        chk("h3_word1", hist_word(), 12'h24A);
        step(B_S);
        chk("h3_submit_ignored", hist_count, 3);
        step(B_C);
        chk("h3_color_ignored", guess_rgb1, 2);
        step(B_M | B_C);
        chk("mode_color_enable", blink_enable, 1);
        chk("mode_color_rgb1", guess_rgb1, 2);
        chk("mode_color_led", blink_led, 1);
        step(B_C | B_R);
        chk("color_over_right_rgb", guess_rgb1, 3);
        chk("color_over_right_led", blink_led, 1);
        chk("pulse_count_11", pulses, 11);

        step(B_S);
        chk("abort_valid_pre", guess_valid, 1);
        rst = 1'b1;
        #1;
        chk("abort_valid_in_rst", guess_valid, 0);
        step(B_R | B_C);
        rst = 1'b0;
        chk("abort_count", hist_count, 0);
        chk("abort_valid", guess_valid, 0);
        chk("rst_beats_buttons_led", blink_led, 0);
        chk("rst_beats_buttons_rgb", guess_word, 12'h249);

        step(B_M);
        chk("h0_enable", blink_enable, 0);
        chk("h0_index", hist_index, 0);
        chk("h0_word", hist_word(), 0);
        step(B_R);
        chk("h0_right_ignored", hist_index, 0);
        step(B_M);
        chk("h0_exit", blink_enable, 1);
        chk("pulse_count_final", pulses, 11);
        chk("sb_drained_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, meaning clk cycles between blink_tick pulses (legal range 2..2^26-1).
REQ-002 SHALL have parameter HIST_DEPTH, default 8, meaning number of stored guesses (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_left  input  1  single-cycle pulse; move cursor/index down.
REQ-006 SHALL have port btn_right  input  1  single-cycle pulse; move cursor/index up.
REQ-007 SHALL have port btn_color  input  1  single-cycle pulse; advance colour of cursor LED.
REQ-008 SHALL have port btn_submit  input  1  single-cycle pulse; commit current guess to history.
REQ-009 SHALL have port btn_mode  input  1  single-cycle pulse; toggle GUESS/HISTORY.
REQ-010 SHALL have port blink_enable  output  1  high in GUESS mode, low in HISTORY mode.
REQ-011 SHALL have port blink_led  output  2  cursor position, 0..3.
REQ-012 SHALL have port blink_tick  output  1  one-cycle pulse every BLINK_DIV cycles.
REQ-013 SHALL have ports guess_rgb0..guess_rgb3  output  3 each  current guess colours.
REQ-014 SHALL have ports history_rgb0..history_rgb3  output  3 each  colours of selected history entry.
REQ-015 SHALL have port hist_count  output  5  number of valid history entries, 0..HIST_DEPTH.
REQ-016 SHALL have port hist_index  output  4  selected history entry.
REQ-017 SHALL have port guess_valid  output  1  one-cycle pulse when a guess is committed.
REQ-018 SHALL have port guess_word  output  12  {guess_rgb3,guess_rgb2,guess_rgb1,guess_rgb0}, valid while guess_valid high.

Function
REQ-019 SHALL implement FSM states GUESS, COMMIT, HISTORY; exactly one active per cycle.
REQ-020 GUESS: btn_mode -> HISTORY next cycle; btn_submit with hist_count<HIST_DEPTH -> COMMIT; else stay.
REQ-021 COMMIT SHALL last exactly one cycle: write guess_word into entry hist_count, increment hist_count, pulse guess_valid, return to GUESS; all buttons ignored in COMMIT.
REQ-022 btn_submit with hist_count==HIST_DEPTH SHALL be ignored (no write, no pulse, no state change).
REQ-023 HISTORY: btn_mode -> GUESS next cycle; btn_submit and btn_color ignored.
REQ-024 Per-cycle priority SHALL be btn_mode > btn_submit > btn_color > btn_right > btn_left; only the highest asserted button acts.
REQ-025 GUESS, btn_right: blink_led +1, 3 wraps to 0; btn_left: blink_led -1, 0 wraps to 3.
REQ-026 GUESS, btn_color: colour at blink_led advances 1->2->...->7->1; colour 000 never produced.
REQ-027 HISTORY, btn_right: hist_index +1, hist_count-1 wraps to 0; btn_left: -1, 0 wraps to hist_count-1; both ignored when hist_count==0.
REQ-028 Entering HISTORY SHALL set hist_index to hist_count-1 (newest), or 0 if hist_count==0.
REQ-029 history_rgb0..3 SHALL be combinational from entry hist_index when hist_count>0, else 3'b000.
REQ-030 blink_enable SHALL be registered: 1 in GUESS and COMMIT, 0 in HISTORY.
REQ-031 Blink counter SHALL count 0..BLINK_DIV-1 and pulse blink_tick in the cycle it wraps to 0.
REQ-032 Any cursor move (REQ-025) or colour change (REQ-026) SHALL restart the blink counter at 0 the next cycle with no blink_tick that cycle.
REQ-033 Guess colours SHALL be unchanged by commit and by mode switches.

Reset
REQ-034 rst SHALL take priority over every button in the same cycle.
REQ-035 On rst: state GUESS, blink_enable 1, blink_led 0, blink counter 0, blink_tick 0, guess_rgb0..3 3'b001, hist_count 0, hist_index 0, guess_valid 0; history storage contents need not be cleared.
REQ-036 rst asserted during COMMIT SHALL abort it: hist_count 0, guess_valid 0 that cycle onward.

Verification
REQ-037 Reset, then 3 btn_right, 1 btn_right -> blink_led 1,2,3,0; guess_rgb all 3'b001.
REQ-038 btn_color x7 at blink_led 2 -> guess_rgb2 steps 2..7 then 1; other LEDs stay 001.
REQ-039 Set guess 7,3,5,1 (rgb0..3), btn_submit -> one cycle later guess_valid=1, guess_word=12'b001_101_011_111, hist_count=1.
REQ-040 Submit HIST_DEPTH+1 times -> hist_count saturates at 8, ninth submit yields no guess_valid.
REQ-041 With hist_count=3, btn_mode -> blink_enable 0, hist_index 2; btn_right -> 0; btn_left -> 2; btn_mode+btn_color same cycle -> only mode toggles.
REQ-042 BLINK_DIV=4: blink_tick every 4th cycle; btn_left mid-count -> next tick 4 cycles after restart.
